// File: rtl/demux_reg_8.sv
// Serial-to-parallel bit demultiplexer: routes one bit per write into an 8-bit staging word.
// Completed words are double-buffered behind a valid/ready output register.
module demux_reg_8 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       strobe,
  input  logic [2:0] sel,
  input  logic       data_input,
  input  logic       auto_inc,
  input  logic       out_ready,
  input  logic       clr_overrun,
  output logic [7:0] data_output,
  output logic       out_valid,
  output logic [2:0] ptr,
  output logic       overrun
);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e     state_q, state_d;
  logic [7:0] staging_q, staging_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] data_q, data_d;
  logic [2:0] ptr_q, ptr_d;
  logic       overrun_q, overrun_d;

  logic       write_en;
  logic [2:0] idx;
  logic [7:0] staging_wr;
  logic [7:0] mask_wr;
  logic       complete;
  logic       handshake;
  logic       load_word;
  logic       set_overrun;

  // Write decode: strobe is an inhibit, so a write happens when it is low.
  always_comb begin
    write_en   = ~strobe;
    idx        = auto_inc ? ptr_q : sel;
    staging_wr = staging_q;
    mask_wr    = mask_q;
    if (write_en) begin
      staging_wr[idx] = data_input;
      mask_wr[idx]    = 1'b1;
    end
    // Completion only when this write fills the last empty slot; rewrites never complete.
    complete  = write_en && (mask_wr == 8'hFF);
    handshake = (state_q == StFull) && out_ready;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    load_word   = 1'b0;
    set_overrun = 1'b0;
    unique case (state_q)
      StFill: begin
        if (complete) begin
          load_word = 1'b1;
          state_d   = StFull;
        end
      end
      StFull: begin
        if (complete && handshake) begin
          load_word = 1'b1;
        end else if (complete) begin
          set_overrun = 1'b1;
        end else if (handshake) begin
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid   = (state_q == StFull);
    data_output = data_q;
    ptr         = ptr_q;
    overrun     = overrun_q;
  end

  // Datapath next-state
  always_comb begin
    staging_d = staging_wr;
    mask_d    = complete ? 8'h00 : mask_wr;
    data_d    = load_word ? staging_wr : data_q;
    if (complete) begin
      ptr_d = 3'd0;
    end else if (write_en && auto_inc) begin
      ptr_d = ptr_q + 3'd1;
    end else begin
      ptr_d = ptr_q;
    end
    // Setting the flag takes priority over a same-cycle clear.
    if (set_overrun) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      staging_q <= 8'h00;
      mask_q    <= 8'h00;
      data_q    <= 8'h00;
      ptr_q     <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      staging_q <= staging_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_demux_reg_8.sv
// Self-checking bench for demux_reg_8: expected words queued at stimulus, popped when out_valid rises.
module tb_demux_reg_8;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       strobe = 1'b1;
  logic [2:0] sel = 3'd0;
  logic       data_input = 1'b0;
  logic       auto_inc = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [7:0] data_output;
  logic       out_valid;
  logic [2:0] ptr;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_w;

  demux_reg_8 dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .strobe      (strobe),
    .sel         (sel),
    .data_input  (data_input),
    .auto_inc    (auto_inc),
    .out_ready   (out_ready),
    .clr_overrun (clr_overrun),
    .data_output (data_output),
    .out_valid   (out_valid),
    .ptr         (ptr),
    .overrun     (overrun)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus drivers: inputs change on the falling edge, outputs sampled 1 time unit after rise.
  task automatic wr(input logic [2:0] s, input logic d, input logic ai, input logic rdy,
                    input logic clr);
    @(negedge clk_i);
    strobe = 1'b0; sel = s; data_input = d; auto_inc = ai; out_ready = rdy; clr_overrun = clr;
    @(posedge clk_i);
    #1;
    strobe = 1'b1; out_ready = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic idle(input logic rdy, input logic clr);
    @(negedge clk_i);
    strobe = 1'b1; out_ready = rdy; clr_overrun = clr;
    @(posedge clk_i);
    #1;
    out_ready = 1'b0; clr_overrun = 1'b0;
  endtask

  // Auto-increment word; sel is driven with junk to show it is ignored.
  task automatic wr_word(input logic [7:0] w, input logic rdy_last, input logic clr_last);
    for (int i = 0; i < 8; i++) begin
      wr(3'(7 - i), w[i], 1'b1, (i == 7) ? rdy_last : 1'b0, (i == 7) ? clr_last : 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    checks++;
    if (data_output !== 8'h00 || out_valid !== 1'b0 || ptr !== 3'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%h valid=%b ptr=%0d ovr=%b want 00 0 0 0",
               data_output, out_valid, ptr, overrun);
    end
    @(negedge clk_i);
    auto_inc = 1'b1;
    strobe = 1'b1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (ptr !== 3'd0) begin
      errors++;
      $display("FAIL reset_release_no_write: got ptr=%0d want 0", ptr);
    end
  endtask

  task automatic test_auto_inc();
    logic [7:0] w;
    w = 8'h4D;
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      wr(3'd0, w[i], 1'b1, 1'b0, 1'b0);
      if (i < 7) begin
        checks++;
        if (ptr !== 3'(i + 1) || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL auto_ptr_step%0d: got ptr=%0d valid=%b want ptr=%0d valid=0",
                   i, ptr, out_valid, i + 1);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || ptr !== 3'd0) begin
      errors++;
      $display("FAIL auto_complete: got valid=%b ptr=%0d want valid=1 ptr=0", out_valid, ptr);
    end
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    if (data_output !== exp_w) begin
      errors++;
      $display("FAIL auto_word: got %h want %h", data_output, exp_w);
    end
    idle(1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || data_output !== 8'h4D) begin
      errors++;
      $display("FAIL auto_consume: got valid=%b data=%h want valid=0 data=4d",
               out_valid, data_output);
    end
  endtask

  task automatic test_sel_dup();
    logic [2:0] sels [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    logic       bits [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_q.push_back(8'h81);
    for (int k = 0; k < 9; k++) begin
      wr(sels[k], bits[k], 1'b0, 1'b0, 1'b0);
      if (k == 3) begin
        checks++;
        if (ptr !== 3'd0) begin
          errors++;
          $display("FAIL sel_ptr_hold: got ptr=%0d want 0", ptr);
        end
      end
      if (k == 7) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL sel_dup_no_complete: got valid=%b want 0", out_valid);
        end
      end
    end
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    if (out_valid !== 1'b1 || data_output !== exp_w) begin
      errors++;
      $display("FAIL sel_word: got valid=%b data=%h want valid=1 data=%h",
               out_valid, data_output, exp_w);
    end
    idle(1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    exp_q.push_back(8'h3C);
    wr_word(8'h3C, 1'b0, 1'b0);
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    if (out_valid !== 1'b1 || data_output !== exp_w || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: got valid=%b data=%h ovr=%b want 1 %h 0",
               out_valid, data_output, overrun, exp_w);
    end
    wr_word(8'hA5, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || data_output !== 8'h3C || out_valid !== 1'b1 || ptr !== 3'd0) begin
      errors++;
      $display("FAIL ovr_set: got ovr=%b data=%h valid=%b ptr=%0d want 1 3c 1 0",
               overrun, data_output, out_valid, ptr);
    end
    idle(1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_clear: got ovr=%b valid=%b want 0 1", overrun, out_valid);
    end
    wr_word(8'h5A, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b1 || data_output !== 8'h3C) begin
      errors++;
      $display("FAIL ovr_set_wins: got ovr=%b data=%h want 1 3c", overrun, data_output);
    end
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || data_output !== 8'h3C || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_drain: got valid=%b data=%h ovr=%b want 0 3c 0",
               out_valid, data_output, overrun);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hE7);
    wr_word(8'h12, 1'b0, 1'b0);
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    if (out_valid !== 1'b1 || data_output !== exp_w) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b data=%h want 1 %h", out_valid, data_output, exp_w);
    end
    wr_word(8'hE7, 1'b1, 1'b0);
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    if (out_valid !== 1'b1 || data_output !== exp_w || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b data=%h ovr=%b want 1 %h 0",
               out_valid, data_output, overrun, exp_w);
    end
    idle(1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_consume: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_strobe_reset();
    logic [7:0] w;
    exp_q.push_back(8'h66);
    wr_word(8'h66, 1'b0, 1'b0);
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    if (out_valid !== 1'b1 || data_output !== exp_w) begin
      errors++;
      $display("FAIL sr_word: got valid=%b data=%h want 1 %h", out_valid, data_output, exp_w);
    end
    for (int i = 0; i < 3; i++) wr(3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0, 1'b0);
      checks++;
      if (ptr !== 3'd3 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL strobe_hold%0d: got ptr=%0d valid=%b want 3 1", i, ptr, out_valid);
      end
    end
    wr(3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ptr !== 3'd4) begin
      errors++;
      $display("FAIL strobe_resume: got ptr=%0d want 4", ptr);
    end
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (data_output !== 8'h00 || out_valid !== 1'b0 || ptr !== 3'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got data=%h valid=%b ptr=%0d ovr=%b want 00 0 0 0",
               data_output, out_valid, ptr, overrun);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    // Upper bits first: a mask surviving reset would complete after four writes.
    w = 8'hF0;
    exp_q.push_back(w);
    for (int k = 0; k < 8; k++) begin
      wr(3'(7 - k), w[7 - k], 1'b0, 1'b0, 1'b0);
      if (k == 3 || k == 6) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL fresh_partial%0d: got valid=%b want 0", k, out_valid);
        end
      end
    end
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    if (out_valid !== 1'b1 || data_output !== exp_w) begin
      errors++;
      $display("FAIL fresh_word: got valid=%b data=%h want 1 %h", out_valid, data_output, exp_w);
    end
    idle(1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_auto_inc();
    test_sel_dup();
    test_overrun();
    test_back_to_back();
    test_strobe_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_reg_8.md
DEMUX_REG_8 -- requirements
Module: demux_reg_8

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port strobe  input  1  active-high inhibit; 1 = no write this cycle, 0 = write enabled.
REQ-004 SHALL have port sel  input  3  destination bit index when auto_inc = 0.
REQ-005 SHALL have port data_input  input  1  serial data bit to route.
REQ-006 SHALL have port auto_inc  input  1  1 = destination from internal pointer, sel ignored.
REQ-007 SHALL have port out_ready  input  1  consumer accepts data_output when out_valid = 1.
REQ-008 SHALL have port clr_overrun  input  1  synchronous clear of overrun flag.
REQ-009 SHALL have port data_output  output  8  registered, assembled word.
REQ-010 SHALL have port out_valid  output  1  data_output holds an unconsumed word.
REQ-011 SHALL have port ptr  output  3  current auto-increment pointer.
REQ-012 SHALL have port overrun  output  1  sticky; a completed word was dropped.

Function
REQ-013 SHALL hold an internal 8-bit staging register and 8-bit written-mask, both invisible at ports.
REQ-014 SHALL perform a write on each edge where strobe = 0: staging[idx] <= data_input, mask[idx] <= 1; idx = ptr if auto_inc = 1, else sel.
REQ-015 SHALL, on a write with auto_inc = 1, advance ptr by 1 modulo 8 (7 -> 0 wrap); with auto_inc = 0 or strobe = 1, ptr holds.
REQ-016 SHALL treat a repeated write to an already-marked index as an overwrite of that bit, not as completion.
REQ-017 SHALL declare a word complete on the edge where the write makes the mask all-ones (8'hFF including the current bit).
REQ-018 SHALL implement two states: FILL (out_valid = 0) and FULL (out_valid = 1).
REQ-019 SHALL, in FILL on completion: data_output <= staging with current bit merged; mask <= 0; ptr <= 0; go to FULL; out_valid = 1 the next cycle (latency one cycle from the last bit's edge).
REQ-020 SHALL, in FULL, hold data_output stable until the edge where out_valid = 1 and out_ready = 1.
REQ-021 SHALL, in FULL, handshake without completion: go to FILL, out_valid <= 0; data_output retains last value.
REQ-022 SHALL keep accepting writes into staging while in FULL (double buffering).
REQ-023 SHALL, in FULL, completion with handshake on the same edge: load new word into data_output, clear mask, ptr <= 0, remain in FULL (out_valid stays 1).
REQ-024 SHALL, in FULL, completion without handshake: drop the new word, keep data_output, clear mask, ptr <= 0, set overrun <= 1.
REQ-025 SHALL clear overrun on an edge with clr_overrun = 1; if a set condition occurs on the same edge, set wins.
REQ-026 SHALL ignore out_ready while in FILL.

Reset
REQ-027 SHALL, when rst_ni = 0, immediately and asynchronously force data_output = 8'h00, out_valid = 0, ptr = 0, overrun = 0, staging = 0, mask = 0, state FILL.
REQ-028 SHALL discard any partially assembled word on reset, including reset asserted mid-word or while in FULL.
REQ-029 SHALL perform no write on the first rising edge coinciding with rst_ni deassertion unless strobe = 0 is sampled at that edge with rst_ni already high.

Verification
REQ-030 SHALL cover: auto_inc = 1, strobe = 0 for 8 cycles with bits 1,0,1,1,0,0,1,0 (ptr 0..7) -> out_valid = 1 next cycle, data_output = 8'h4D, ptr = 0.
REQ-031 SHALL cover: auto_inc = 0, sel 7,6,...,0 with data_input = 1 on sel 0 and 7 only -> data_output = 8'h81; a duplicate sel = 3 write before completion delays out_valid by one write.
REQ-032 SHALL cover: word complete, out_ready = 0, second full word written -> overrun = 1, data_output unchanged; clr_overrun = 1 -> overrun = 0 next cycle.
REQ-033 SHALL cover: out_ready = 1 on same edge as second word's completion -> out_valid stays 1, data_output = second word, overrun = 0.
REQ-034 SHALL cover: strobe = 1 for 5 cycles mid-word -> no mask/ptr change; rst_ni pulsed low after 4 bits -> all outputs 0 asynchronously, subsequent 8 writes produce a fresh word.
